// File: rtl/fifo_shift_round_pkg.sv
// Shared helpers for the width-converting buffer: ratio, legality check, counter width.
// Latency: none (elaboration-time functions only).
// Backpressure: not applicable.
package fifo_shift_round_pkg;

    // Legal only when the wider side is a whole multiple of the narrower side.
    function automatic bit width_ok(int iw, int ow);
        if (iw <= 0 || ow <= 0) return 1'b0;
        return (iw >= ow) ? ((iw % ow) == 0) : ((ow % iw) == 0);
    endfunction

    // Number of narrow chunks that make up one wide word.
    function automatic int ratio(int wide, int narrow);
        return wide / narrow;
    endfunction

    // Counter/index width able to hold 0..r inclusive.
    function automatic int cnt_width(int r);
        return (r < 1) ? 1 : $clog2(r + 1);
    endfunction

endpackage

// File: rtl/fifo_shift_round_if.sv
// Bundles both stream sides of the width converter: narrow/wide input and output.
// Latency: none (wiring only).
// Backpressure: InAccept throttles the producer, OutReady throttles the block.
interface fifo_shift_round_if #(
    parameter int IWidth = 1,
    parameter int OWidth = 1
);
    logic [IWidth-1:0] InData;
    logic              InValid;
    logic              InAccept;
    logic [OWidth-1:0] OutData;
    logic              OutValid;
    logic              OutReady;

    modport slave (
        input  InData, InValid, OutReady,
        output InAccept, OutData, OutValid
    );

    modport master (
        output InData, InValid, OutReady,
        input  InAccept, OutData, OutValid
    );
endinterface

// File: rtl/fifo_shift_round_up.sv
// Packs OWidth/IWidth consecutive input chunks into one output word, first chunk in LSBs.
// Latency: OutValid rises the cycle after the last chunk of a word is accepted.
// Backpressure: refuses input while full; with Register=0 a draining word frees the slot same cycle.
module fifo_shift_round_up
    import fifo_shift_round_pkg::*;
#(
    parameter int IWidth   = 1,
    parameter int OWidth   = 2,
    parameter bit Register = 1'b0
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [IWidth-1:0] in_data,
    input  logic              in_vld,
    output logic              in_acc,
    output logic [OWidth-1:0] out_data,
    output logic              out_vld,
    input  logic              out_rdy
);
    localparam int R  = ratio(OWidth, IWidth);
    localparam int CW = cnt_width(R);
    localparam logic [CW-1:0] CntFull = CW'(R);

    logic [CW-1:0]     count_q, count_d;
    logic [OWidth-1:0] store_q, store_d;
    logic [CW-1:0]     slot;
    logic              in_xfer, out_xfer;

    assign out_vld  = (count_q == CntFull);
    assign out_data = store_q;
    assign in_acc   = (count_q < CntFull) || (Register == 1'b0 && out_vld && out_rdy);
    assign in_xfer  = in_vld && in_acc;
    assign out_xfer = out_vld && out_rdy;

    // Next count and chunk placement; a draining word restarts packing at slot 0.
    always_comb begin
        count_d = count_q;
        store_d = store_q;
        slot    = count_q;
        if (out_xfer) begin
            count_d = '0;
            slot    = '0;
        end
        if (in_xfer) begin
            for (int k = 0; k < R; k++) begin
                if (slot == CW'(k)) store_d[k*IWidth +: IWidth] = in_data;
            end
            count_d = slot + CW'(1);
        end
    end

    // State register; reset discards any partially packed word.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            count_q <= '0;
            store_q <= '0;
        end else begin
            count_q <= count_d;
            store_q <= store_d;
        end
    end
endmodule

// File: rtl/fifo_shift_round.sv
// Valid/ready width converter: packs narrow chunks up, or serialises wide words down (LSB first).
// Latency: one cycle from the completing input transfer to OutValid.
// Backpressure: stalls hold OutData/OutValid; Register=1 removes the OutReady->InAccept path.
module fifo_shift_round
    import fifo_shift_round_pkg::*;
#(
    parameter int IWidth   = 1,
    parameter int OWidth   = 1,
    parameter bit Register = 1'b0
) (
    input  logic              Clock,
    input  logic              Reset,
    fifo_shift_round_if.slave io
);
    if (!width_ok(IWidth, OWidth)) begin : g_bad_widths
        $error("fifo_shift_round: wider width must be an integer multiple of the narrower");
    end

    if (IWidth < OWidth) begin : g_up
        fifo_shift_round_up #(
            .IWidth   (IWidth),
            .OWidth   (OWidth),
            .Register (Register)
        ) u_up (
            .Clock    (Clock),
            .Reset    (Reset),
            .in_data  (io.InData),
            .in_vld   (io.InValid),
            .in_acc   (io.InAccept),
            .out_data (io.OutData),
            .out_vld  (io.OutValid),
            .out_rdy  (io.OutReady)
        );
    end else begin : g_down
        // Equal widths fall out of this path as a single-entry buffer (R=1).
        localparam int R  = ratio(IWidth, OWidth);
        localparam int CW = cnt_width(R);
        localparam logic [CW-1:0] IdxLast = CW'(R - 1);

        logic [IWidth-1:0] store_q, store_d;
        logic [CW-1:0]     idx_q, idx_d;
        logic              full_q, full_d;
        logic              last, in_xfer, out_xfer;
        logic [OWidth-1:0] chunk;

        assign last        = (idx_q == IdxLast);
        assign io.InAccept = !full_q || (Register == 1'b0 && last && io.OutReady);
        assign io.OutValid = full_q;
        assign io.OutData  = chunk;
        assign in_xfer     = io.InValid && io.InAccept;
        assign out_xfer    = full_q && io.OutReady;

        // Select the chunk addressed by the index from the stored word.
        always_comb begin
            chunk = '0;
            for (int k = 0; k < R; k++) begin
                if (idx_q == CW'(k)) chunk = store_q[k*OWidth +: OWidth];
            end
        end

        // Advance through chunks; a new word loads at index 0, possibly alongside the last chunk.
        always_comb begin
            store_d = store_q;
            idx_d   = idx_q;
            full_d  = full_q;
            if (out_xfer) begin
                if (last) begin
                    idx_d  = '0;
                    full_d = 1'b0;
                end else begin
                    idx_d = idx_q + CW'(1);
                end
            end
            if (in_xfer) begin
                store_d = io.InData;
                idx_d   = '0;
                full_d  = 1'b1;
            end
        end

        // State register; reset empties the buffer and clears the word.
        always_ff @(posedge Clock or negedge Reset) begin
            if (!Reset) begin
                store_q <= '0;
                idx_q   <= '0;
                full_q  <= 1'b0;
            end else begin
                store_q <= store_d;
                idx_q   <= idx_d;
                full_q  <= full_d;
            end
        end
    end
endmodule

// File: tb/tb_fifo_shift_round.sv
// Directed bench for up (1->32, 64->512 registered), down (512->64) and equal (32->32) variants.
// Latency: checks the one-cycle fill-to-valid latency and same-cycle refill paths.
// Backpressure: exercises stalls, the registered bubble and refusal while full.
module tb_fifo_shift_round;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_shift_round_if #(.IWidth(1),   .OWidth(32))  if_up ();
    fifo_shift_round_if #(.IWidth(64),  .OWidth(512)) if_ur ();
    fifo_shift_round_if #(.IWidth(512), .OWidth(64))  if_dn ();
    fifo_shift_round_if #(.IWidth(32),  .OWidth(32))  if_eq ();

    fifo_shift_round #(.IWidth(1),   .OWidth(32),  .Register(1'b0)) u_up (.Clock(clk), .Reset(rst_n), .io(if_up));
    fifo_shift_round #(.IWidth(64),  .OWidth(512), .Register(1'b1)) u_ur (.Clock(clk), .Reset(rst_n), .io(if_ur));
    fifo_shift_round #(.IWidth(512), .OWidth(64),  .Register(1'b0)) u_dn (.Clock(clk), .Reset(rst_n), .io(if_dn));
    fifo_shift_round #(.IWidth(32),  .OWidth(32),  .Register(1'b0)) u_eq (.Clock(clk), .Reset(rst_n), .io(if_eq));

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic        in_vld;
        logic        out_rdy;
        logic        exp_acc;
        logic        exp_vld;
        logic [63:0] exp_dat;
    } dvec_t;

    dvec_t tbl [18];

    logic [511:0] w_tab, w1, w2, e_up;
    logic [31:0]  p1, p2, p3;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        p1 = 32'h2C5A_F00D;
        p2 = 32'h9E37_79B9;
        p3 = 32'h1234_5670;
        for (int k = 0; k < 8; k++) begin
            w_tab[k*64 +: 64] = 64'h100 + 64'(k);
            w1[k*64 +: 64]    = 64'h200 + 64'(k);
            w2[k*64 +: 64]    = 64'h300 + 64'(k);
            e_up[k*64 +: 64]  = 64'(k);
        end
        tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 64'h0};
        for (int k = 0; k < 8; k++) begin
            tbl[1 + 2*k] = '{1'b0, 1'b0, 1'b0, 1'b1, 64'h100 + 64'(k)};
            tbl[2 + 2*k] = '{1'b0, 1'b1, (k == 7), 1'b1, 64'h100 + 64'(k)};
        end
        tbl[17] = '{1'b0, 1'b1, 1'b1, 1'b0, 64'h0};

        if_up.InData = '0; if_up.InValid = 1'b0; if_up.OutReady = 1'b0;
        if_ur.InData = '0; if_ur.InValid = 1'b0; if_ur.OutReady = 1'b0;
        if_dn.InData = '0; if_dn.InValid = 1'b0; if_dn.OutReady = 1'b0;
        if_eq.InData = '0; if_eq.InValid = 1'b0; if_eq.OutReady = 1'b0;

        // Reset state of every variant
        #12;
        chk("rst_up_vld", 512'(if_up.OutValid), 512'(1'b0));
        chk("rst_up_acc", 512'(if_up.InAccept), 512'(1'b1));
        chk("rst_up_dat", 512'(if_up.OutData),  512'(0));
        chk("rst_ur_vld", 512'(if_ur.OutValid), 512'(1'b0));
        chk("rst_ur_acc", 512'(if_ur.InAccept), 512'(1'b1));
        chk("rst_ur_dat", if_ur.OutData,        512'(0));
        chk("rst_dn_vld", 512'(if_dn.OutValid), 512'(1'b0));
        chk("rst_dn_acc", 512'(if_dn.InAccept), 512'(1'b1));
        chk("rst_dn_dat", 512'(if_dn.OutData),  512'(0));
        chk("rst_eq_vld", 512'(if_eq.OutValid), 512'(1'b0));
        chk("rst_eq_acc", 512'(if_eq.InAccept), 512'(1'b1));
        chk("rst_eq_dat", 512'(if_eq.OutData),  512'(0));
        tick();
        rst_n = 1'b1;
        tick();

        // Down 512->64 table: load one word, then alternate stall/transfer per chunk
        for (int i = 0; i < 18; i++) begin
            if_dn.InValid  = tbl[i].in_vld;
            if_dn.InData   = tbl[i].in_vld ? w_tab : ~w_tab;
            if_dn.OutReady = tbl[i].out_rdy;
            #1;
            chk($sformatf("dn_acc[%0d]", i), 512'(if_dn.InAccept), 512'(tbl[i].exp_acc));
            chk($sformatf("dn_vld[%0d]", i), 512'(if_dn.OutValid), 512'(tbl[i].exp_vld));
            if (tbl[i].exp_vld) chk($sformatf("dn_dat[%0d]", i), 512'(if_dn.OutData), 512'(tbl[i].exp_dat));
            tick();
        end

        // Down back-to-back: next word accepted on the last-chunk transfer, no gap
        if_dn.OutReady = 1'b1;
        if_dn.InValid  = 1'b1;
        if_dn.InData   = w1;
        #1;
        chk("b2b_load_acc", 512'(if_dn.InAccept), 512'(1'b1));
        tick();
        if_dn.InValid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            #1;
            chk($sformatf("b2b_w1_dat[%0d]", k), 512'(if_dn.OutData), 512'(64'h200 + 64'(k)));
            tick();
        end
        if_dn.InValid = 1'b1;
        if_dn.InData  = w2;
        #1;
        chk("b2b_last_acc", 512'(if_dn.InAccept), 512'(1'b1));
        chk("b2b_last_vld", 512'(if_dn.OutValid), 512'(1'b1));
        chk("b2b_last_dat", 512'(if_dn.OutData),  512'(64'h207));
        tick();
        if_dn.InValid = 1'b0;
        if_dn.InData  = '0;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk($sformatf("b2b_w2_vld[%0d]", k), 512'(if_dn.OutValid), 512'(1'b1));
            chk($sformatf("b2b_w2_dat[%0d]", k), 512'(if_dn.OutData),  512'(64'h300 + 64'(k)));
            tick();
        end
        #1;
        chk("b2b_drained_vld", 512'(if_dn.OutValid), 512'(1'b0));
        if_dn.OutReady = 1'b0;

        // Up 1->32, Register=0: continuous stream, one word every 32 cycles with no bubble
        if_up.OutReady = 1'b1;
        if_up.InValid  = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if_up.InData = p1[i];
            #1;
            chk($sformatf("up_acc_a[%0d]", i), 512'(if_up.InAccept), 512'(1'b1));
            chk($sformatf("up_vld_a[%0d]", i), 512'(if_up.OutValid), 512'(1'b0));
            tick();
        end
        for (int i = 0; i < 32; i++) begin
            if_up.InData = p2[i];
            #1;
            chk($sformatf("up_acc_b[%0d]", i), 512'(if_up.InAccept), 512'(1'b1));
            chk($sformatf("up_vld_b[%0d]", i), 512'(if_up.OutValid), 512'(i == 0));
            if (i == 0) chk("up_word1", 512'(if_up.OutData), 512'(p1));
            tick();
        end
        if_up.InValid = 1'b0;
        #1;
        chk("up_word2_vld", 512'(if_up.OutValid), 512'(1'b1));
        chk("up_word2",     512'(if_up.OutData),  512'(p2));
        tick();
        chk("up_empty_vld", 512'(if_up.OutValid), 512'(1'b0));
        if_up.OutReady = 1'b0;

        // Up 64->512, Register=1: fill, stall, then the output cycle refuses input
        if_ur.InValid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if_ur.InData = 64'(k);
            #1;
            chk($sformatf("ur_acc[%0d]", k), 512'(if_ur.InAccept), 512'(1'b1));
            tick();
        end
        if_ur.InData = 64'h8;
        #1;
        chk("ur_full_acc", 512'(if_ur.InAccept), 512'(1'b0));
        chk("ur_full_vld", 512'(if_ur.OutValid), 512'(1'b1));
        chk("ur_full_dat", if_ur.OutData, e_up);
        tick();
        if_ur.OutReady = 1'b1;
        #1;
        chk("ur_bubble_acc", 512'(if_ur.InAccept), 512'(1'b0));
        chk("ur_stall_vld",  512'(if_ur.OutValid), 512'(1'b1));
        chk("ur_stall_dat",  if_ur.OutData, e_up);
        tick();
        chk("ur_after_vld", 512'(if_ur.OutValid), 512'(1'b0));
        chk("ur_after_acc", 512'(if_ur.InAccept), 512'(1'b1));
        if_ur.InValid  = 1'b0;
        if_ur.OutReady = 1'b0;

        // Equal 32->32: single entry, second word refused while the first is stalled
        if_eq.InValid = 1'b1;
        if_eq.InData  = 32'hDEAD_BEEF;
        #1;
        chk("eq_acc1", 512'(if_eq.InAccept), 512'(1'b1));
        tick();
        if_eq.InData = 32'hCAFE_F00D;
        #1;
        chk("eq_vld1",    512'(if_eq.OutValid), 512'(1'b1));
        chk("eq_dat1",    512'(if_eq.OutData),  512'(32'hDEAD_BEEF));
        chk("eq_refused", 512'(if_eq.InAccept), 512'(1'b0));
        tick();
        chk("eq_hold_dat", 512'(if_eq.OutData), 512'(32'hDEAD_BEEF));
        if_eq.OutReady = 1'b1;
        #1;
        chk("eq_swap_acc", 512'(if_eq.InAccept), 512'(1'b1));
        tick();
        if_eq.InValid = 1'b0;
        #1;
        chk("eq_vld2", 512'(if_eq.OutValid), 512'(1'b1));
        chk("eq_dat2", 512'(if_eq.OutData),  512'(32'hCAFE_F00D));
        tick();
        chk("eq_empty_vld", 512'(if_eq.OutValid), 512'(1'b0));
        if_eq.OutReady = 1'b0;

        // Reset mid-word on the 1->32 packer: partial chunks are discarded
        if_up.InValid = 1'b1;
        if_up.InData  = 1'b1;
        repeat (5) tick();
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", 512'(if_up.OutValid), 512'(1'b0));
        chk("mid_rst_acc", 512'(if_up.InAccept), 512'(1'b1));
        chk("mid_rst_dat", 512'(if_up.OutData),  512'(0));
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if_up.InData = p3[i];
            #1;
            chk($sformatf("post_rst_vld[%0d]", i), 512'(if_up.OutValid), 512'(1'b0));
            tick();
        end
        if_up.InValid = 1'b0;
        #1;
        chk("post_rst_word_vld", 512'(if_up.OutValid), 512'(1'b1));
        chk("post_rst_word",     512'(if_up.OutData),  512'(p3));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/fifo_shift_round.md
Name: fifo_shift_round

Overview:
- Valid/ready width-converting buffer between two streams of different word width.
- Up-conversion (IWidth < OWidth): packs OWidth/IWidth consecutive input chunks into one output word.
- Down-conversion (IWidth > OWidth): serialises each input word into IWidth/OWidth output chunks.
- Used wherever bus width changes, e.g. bit-serial PRNG to address word, FE data bus to ORAM block.

Parameters:
- IWidth, 1: input data width in bits.
- OWidth, 1: output data width in bits. The larger of IWidth/OWidth must be an integer multiple of the smaller; elaboration fails otherwise.
- Register, 0: 0 = InAccept may depend combinationally on OutReady (full throughput). 1 = no combinational OutReady->InAccept path (one bubble per output word).

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset.
- InData  in  IWidth  input word/chunk.
- InValid  in  1  InData valid.
- InAccept  out  1  block accepts InData this cycle.
- OutData  out  OWidth  output word/chunk.
- OutValid  out  1  OutData valid.
- OutReady  in  1  consumer takes OutData this cycle.

Behaviour:
- Transfers: input when InValid&InAccept at the rising edge; output when OutValid&OutReady. A transfer does not depend on any other signal.
- R = max(IWidth,OWidth)/min(IWidth,OWidth). Internal state: R-slot chunk store of min width, plus a count/index register of log2(R+1) bits.
- Reset (asynchronous, Reset=0):
  - count/index = 0, store = 0.
  - OutValid = 0, InAccept = 1, OutData = 0.
- Up-conversion:
  - The k-th accepted chunk (k=0..R-1) lands in OutData bits [(k+1)*IWidth-1 : k*IWidth]. The first chunk is in the LSBs.
  - OutValid = (count == R). OutData comes straight from the store.
  - InAccept = (count < R) | (Register==0 & count==R & OutReady).
  - Output transfer without input transfer: count -> 0.
  - Simultaneous output and input transfer (Register=0 only): count -> 1, with the new chunk in slot 0.
  - Latency: OutValid rises the cycle after the R-th input transfer.
- Down-conversion:
  - On input accept: store the word, index = 0, full = 1.
  - OutData = chunk[index] = InData bits [(index+1)*OWidth-1 : index*OWidth] of the stored word (LSB chunk first).
  - OutValid = full. Each output transfer increments index.
  - An output transfer at index = R-1 empties the block.
  - InAccept = ~full | (Register==0 & index==R-1 & OutReady).
  - Simultaneous last-chunk output and input transfer (Register=0 only): the new word is loaded at index 0, and OutValid stays 1.
- IWidth == OWidth: single-entry buffer, identical to down-conversion with R=1.
- Data stalls: OutData and OutValid hold stable while OutValid & ~OutReady. Input chunks are never dropped or duplicated.
- InData is ignored when not accepted. X on InData while InValid=0 must not propagate to OutData.
- Reset asserted mid-word: the partial word is discarded and the block restarts empty on the next valid input.

Decomposition:
- Shared package/header holds the `log2` macro and a ratio/width-check function.
- One natural sub-module, `fifo_shift_round_up`, covers the packing path. The down/equal path stays inline, selected by a generate on IWidth vs OWidth.

Test Plan:
- Up 1->32, Register=0: InValid held 1, serial bits 1,0,1,1,0...; after 32 accepts OutValid=1 and OutData[0]=first bit, OutData[31]=32nd bit. OutReady=1 gives a word every 32 cycles with no bubble.
- Up 64->512, Register=1: 8 chunks 0x0..0x7 -> OutData 0x7_..._0 (chunk k at bits 64k+63:64k). InAccept=0 while full and stays 0 for the output cycle (one bubble).
- Down 512->64: word with chunk k = 0x100+k; OutReady toggling 1,0,1... -> outputs 0x100..0x107 in order, each held stable while stalled. InAccept returns 1 only with the last chunk's transfer.
- Back-to-back down, Register=0: new word offered at the last-chunk transfer -> accepted in the same cycle, OutValid never drops, next chunk 0 follows immediately.
- Equal 32->32: value 0xDEADBEEF -> OutValid next cycle with the same data. With OutReady=0 a second input is refused (InAccept=0).
- Reset low after 5 of 32 chunks: OutValid=0, InAccept=1 asynchronously. The next 32 accepts produce a word containing only post-reset data.
